result_streamer: RTL and testbench

//  Drains the SIMD result BRAM (R). It is the reader of the R port that the datapath writes.
//  On start it reads word_count rows from base_addr onward. Each row holds PE_COUNT lanes.

---
 rtl/simd_stream_pkg.sv | 13 +
 rtl/result_streamer_lane_serializer.sv | 71 +++++++
 rtl/result_streamer.sv | 117 +++++++++++
 tb/tb_result_streamer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/simd_stream_pkg.sv
// Shared types for the SIMD result streaming path: FSM state encoding and row layout.
package simd_stream_pkg;

  localparam int PE_COUNT   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int LANE_IDX_W = $clog2(PE_COUNT);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, FINISH} rs_state_t;

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/result_streamer_lane_serializer.sv
// Row buffer plus lane index: presents one lane per beat, lane 0 first, with a one-row prefetch slot.
module lane_serializer
  import simd_stream_pkg::*;
#(
  parameter int PE_COUNT   = simd_stream_pkg::PE_COUNT,
  parameter int DATA_WIDTH = simd_stream_pkg::DATA_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 active_i,
  input  logic                                 dout_vld_i,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  dout_i,
  input  logic                                 tready_i,
  output logic [DATA_WIDTH-1:0]                tdata_o,
  output logic                                 tvalid_o,
  output logic                                 lane_last_o,
  output logic                                 row_consumed_o
);

  localparam int LW = $clog2(PE_COUNT);
  localparam logic [LW-1:0] LANE_LAST = LW'(PE_COUNT - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  logic [PE_COUNT-1:0][DATA_WIDTH-1:0] cur_row_q, nxt_row_q, row_src;
  logic                                cur_vld_q, nxt_vld_q, hs;
  logic [LW-1:0]                       lane_q;

  // The first row of a drain is shown straight from the BRAM output so the
  // first beat is not delayed by a capture cycle.
  always_comb begin
    row_src        = cur_vld_q ? cur_row_q : dout_i;
    tvalid_o       = active_i & (cur_vld_q | dout_vld_i);
    hs             = tvalid_o & tready_i;
    lane_last_o    = (lane_q == LANE_LAST);
    row_consumed_o = hs & lane_last_o;
    tdata_o        = tvalid_o ? row_src[lane_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst || !active_i) begin
      cur_vld_q <= 1'b0;
      nxt_vld_q <= 1'b0;
      lane_q    <= '0;
    end else begin
      if (dout_vld_i && !cur_vld_q) begin
        cur_row_q <= dout_i;
        cur_vld_q <= 1'b1;
      end else if (dout_vld_i) begin
        nxt_row_q <= dout_i;
        nxt_vld_q <= 1'b1;
      end
      if (hs) begin
        if (lane_last_o) begin
          lane_q <= '0;
          if (nxt_vld_q) begin
            cur_row_q <= nxt_row_q;
            nxt_vld_q <= 1'b0;
          end else if (dout_vld_i) begin
            cur_row_q <= dout_i;
            nxt_vld_q <= 1'b0;
          end else begin
            cur_vld_q <= 1'b0;
          end
        end else begin
          lane_q <= lane_q + LANE_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/result_streamer.sv
// Drains word_count rows of the R BRAM onto a valid/ready beat stream, lane 0 first.
// RESULT_STREAMER_ROW_LAST_EN: tlast on every row end instead of only the final beat.
module result_streamer
  import simd_stream_pkg::*;
#(
  parameter int PE_COUNT   = simd_stream_pkg::PE_COUNT,
  parameter int DATA_WIDTH = simd_stream_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = simd_stream_pkg::ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [ADDR_WIDTH-1:0]                base_addr,
  input  logic [ADDR_WIDTH:0]                  word_count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 bram_r_rd_en,
  output logic [ADDR_WIDTH-1:0]                bram_r_raddr,
  input  logic [PE_COUNT-1:0][DATA_WIDTH-1:0]  bram_r_dout,
  output logic [DATA_WIDTH-1:0]                m_tdata,
  output logic                                 m_tvalid,
  input  logic                                 m_tready,
  output logic                                 m_tlast
);

  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  rs_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   req_left_q, rows_rem_q;
  logic                  pf_q, rd_fire_q;
  logic                  stream_act, pf_fire, row_consumed, lane_last, final_row;

  always_comb begin
    stream_act = (state_q == STREAM);
    pf_fire    = stream_act & pf_q & (req_left_q != '0);
    final_row  = (rows_rem_q == CNT_ONE);
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    done         = 1'b0;
    bram_r_rd_en = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = (word_count == '0) ? FINISH : FETCH;
      FETCH: begin
        busy         = 1'b1;
        bram_r_rd_en = 1'b1;
        state_d      = STREAM;
      end
      STREAM: begin
        busy         = 1'b1;
        bram_r_rd_en = pf_fire;
        if (row_consumed && final_row) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bram_r_raddr = addr_q;

  // One read is outstanding per current row: pf_q re-arms whenever a row starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      rows_rem_q <= '0;
      pf_q       <= 1'b0;
      rd_fire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_fire_q <= bram_r_rd_en;
      if (state_q == IDLE && start) begin
        addr_q     <= base_addr;
        req_left_q <= word_count;
        rows_rem_q <= word_count;
      end
      if (bram_r_rd_en) begin
        addr_q     <= addr_q + ADDR_ONE;
        req_left_q <= req_left_q - CNT_ONE;
      end
      if (row_consumed) rows_rem_q <= rows_rem_q - CNT_ONE;
      if (state_q == FETCH || row_consumed) pf_q <= 1'b1;
      else if (pf_fire)                     pf_q <= 1'b0;
    end
  end

  lane_serializer #(
    .PE_COUNT   (PE_COUNT),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ser (
    .clk            (clk),
    .rst            (rst),
    .active_i       (stream_act),
    .dout_vld_i     (rd_fire_q & stream_act),
    .dout_i         (bram_r_dout),
    .tready_i       (m_tready),
    .tdata_o        (m_tdata),
    .tvalid_o       (m_tvalid),
    .lane_last_o    (lane_last),
    .row_consumed_o (row_consumed)
  );

`ifdef RESULT_STREAMER_ROW_LAST_EN
  assign m_tlast = m_tvalid & lane_last;
`else
  assign m_tlast = m_tvalid & lane_last & final_row;
`endif

endmodule

// File: tb/tb_result_streamer.sv
// Randomized bench for result_streamer against a row/lane beat-list reference model.
module tb_result_streamer;
  import simd_stream_pkg::*;

  localparam int PE = simd_stream_pkg::PE_COUNT;
  localparam int DW = simd_stream_pkg::DATA_WIDTH;
  localparam int AW = simd_stream_pkg::ADDR_WIDTH;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, rd_en, tvalid, tready, tlast;
  logic [AW-1:0] base_addr, raddr;
  logic [AW:0]   word_count;
  logic [DW-1:0] tdata;
  row_t          dout;
  row_t          mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  result_streamer #(
    .PE_COUNT   (PE),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .bram_r_rd_en (rd_en),
    .bram_r_raddr (raddr),
    .bram_r_dout  (dout),
    .m_tdata      (tdata),
    .m_tvalid     (tvalid),
    .m_tready     (tready),
    .m_tlast      (tlast)
  );

  // R BRAM: one-cycle registered read
  always @(posedge clk) if (rd_en) dout <= mem[raddr];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  logic [AW-1:0] exp_addr [$];

  task automatic plan(input logic [AW-1:0] b, input int cnt);
    for (int r = 0; r < cnt; r++) begin
      logic [AW-1:0] a;
      a = b + AW'(r);
      exp_addr.push_back(a);
      for (int l = 0; l < (1 << LANE_IDX_W); l++) begin
        exp_data.push_back(mem[a][l]);
`ifdef RESULT_STREAMER_ROW_LAST_EN
        exp_last.push_back(l == PE - 1);
`else
        exp_last.push_back((r == cnt - 1) && (l == PE - 1));
`endif
      end
    end
  endtask

  // mode: 0 = always ready, 1 = toggling, 2 = random
  task automatic drain(input logic [AW-1:0] b, input int cnt, input int mode,
                       input int abort_after, input bit restart_mid, input bit start_at_finish);
    int first_v, last_hs, done_c, beats, exp_lh, seen;
    bit prev_stall, aborted;
    logic [DW-1:0] prev_d;
    logic prev_l;
    int rdy [$];
    first_v = -1; last_hs = -1; done_c = -1; beats = 0; exp_lh = -1;
    prev_stall = 0; aborted = 0; prev_d = '0; prev_l = 0;
    plan(b, cnt);
    @(posedge clk); #1;
    base_addr = b; word_count = (AW+1)'(cnt); start = 1'b1; tready = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      rdy.push_back(int'(tready));
      if (prev_stall) begin
        chk("stall_valid", tvalid, 1);
        chk("stall_data", tdata, prev_d);
        chk("stall_last", tlast, prev_l);
      end
      if (tvalid && first_v < 0) first_v = i;
      if (rd_en) begin
        if (exp_addr.size() == 0) chk("extra_read", 1, 0);
        else chk("raddr", raddr, exp_addr.pop_front());
      end
      if (tvalid && tready) begin
        if (exp_data.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("tdata", tdata, exp_data.pop_front());
          chk("tlast", tlast, exp_last.pop_front());
        end
        beats++;
        last_hs = i;
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
      if (done) begin
        done_c = i;
        chk("busy_at_done", busy, 0);
        break;
      end
      chk(i == 0 ? "busy_before_accept" : "busy", busy, i == 0 ? 0 : 1);
      if (abort_after >= 0 && beats == abort_after + 1) begin
        @(posedge clk); #1 rst = 1'b1; start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", tvalid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_rd", rd_en, 0);
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_mid && i == 2) begin
        start = 1'b1; base_addr = b ^ AW'('h155); word_count = (AW+1)'(3);
      end
      case (mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = ($urandom_range(0, 99) < 60);
      endcase
    end
    if (aborted) return;
    if (done_c < 0) chk("done_timeout", 0, 1);
    chk("beats_left", exp_data.size(), 0);
    chk("reads_left", exp_addr.size(), 0);
    chk("beat_count", beats, cnt * PE);
    if (cnt == 0) begin
      chk("zero_done_cycle", done_c, 1);
      chk("zero_no_valid", first_v < 0, 1);
    end else begin
      chk("latency", first_v, 2);
      seen = 0;
      for (int k = first_v; k < rdy.size(); k++) begin
        if (rdy[k] != 0) begin
          seen++;
          if (seen == cnt * PE) begin exp_lh = k; break; end
        end
      end
      chk("last_beat_cycle", last_hs, exp_lh);
      chk("done_cycle", done_c, last_hs + 1);
    end
    if (start_at_finish) begin
      start = 1'b1; base_addr = b; word_count = (AW+1)'(2);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      chk("post_done", done, 0);
      chk("post_busy", busy, 0);
      chk("post_rd", rd_en, 0);
      chk("post_valid", tvalid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; tready = 1'b1;
    base_addr = '0; word_count = (AW+1)'(5);
    for (int r = 0; r < (1 << AW); r++)
      for (int l = 0; l < PE; l++) mem[r][l] = $urandom;
    for (int l = 0; l < PE; l++) begin
      mem[16][l] = DW'(l);
      mem[17][l] = DW'(PE + l);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", rd_en, 0);
    chk("rst_raddr", raddr, 0);
    chk("rst_valid", tvalid, 0);
    chk("rst_last", tlast, 0);
    chk("rst_data", tdata, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_ignored", busy, 0);
    chk("rst_start_no_rd", rd_en, 0);

    drain(AW'('h010), 2, 0, -1, 0, 0);
    drain(AW'('h010), 2, 1, -1, 0, 0);
    drain(AW'('h123), 0, 0, -1, 0, 0);
    drain(AW'('h3FF), 2, 0, -1, 1, 1);
    drain(AW'('h005), 4, 0, 3, 0, 0);
    drain(AW'('h005), 4, 0, -1, 0, 0);
    for (int t = 0; t < 12; t++)
      drain(AW'($urandom), $urandom_range(1, 6), 2, -1, 1'($urandom), 1'($urandom));
    drain(AW'('h2A5), 1 << AW, 2, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
